// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider family: FSM state encoding
// and the magnitude helper used when loading signed operands.
package div_pkg;

  // Control states of the divider.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Widest operand the magnitude helper handles; callers extend to this width.
  localparam int MAX_W = 64;

  // Magnitude of a (sign-extended) operand. Negates only for signed requests
  // with a negative value. For MIN the result is 2^(WIDTH-1) once truncated,
  // which is then treated as an unsigned magnitude.
  function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value,
                                               input logic             sgn);
    logic [MAX_W-1:0] mag;
    if (sgn && value[MAX_W-1]) begin
      mag = {MAX_W{1'b0}} - value;
    end else begin
      mag = value;
    end
    return mag;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor magnitude when it fits.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] dvs_ext_s;
  logic             fits_s;

  // Trial subtraction; restore (keep the shifted value) when it does not fit.
  always_comb begin
    shifted_s = {rem, q_msb};
    dvs_ext_s = {2'b00, dvs};
    fits_s    = (shifted_s >= dvs_ext_s);
    if (fits_s) begin
      rem_next = (WIDTH+1)'(shifted_s - dvs_ext_s);
      q_bit    = 1'b1;
    end else begin
      rem_next = (WIDTH+1)'(shifted_s);
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with signed/unsigned mode, quotient
// and remainder outputs, divide-by-zero and signed-overflow flags, behind a
// start/done handshake. Fixed latency of WIDTH+1 edges for normal requests.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Control state
  state_e           state_r;
  state_e           state_nxt_s;

  // Datapath registers
  logic [WIDTH-1:0] q_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CNT_W-1:0] cnt_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             ovf_pend_r;

  // Registered outputs
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             busy_r;
  logic             done_r;
  logic             dz_r;
  logic             ovf_r;

  // Combinational helpers
  logic [MAX_W-1:0] dvd_ext_s;
  logic [MAX_W-1:0] dvs_ext_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;
  logic             accept_s;
  logic             div_zero_s;
  logic             load_s;
  logic             dz_ev_s;
  logic             min_s;
  logic [WIDTH:0]   rem_nxt_s;
  logic             q_bit_s;
  logic [WIDTH-1:0] fix_q_s;
  logic [WIDTH-1:0] fix_r_s;

  // Operand magnitudes and request decode for the IDLE acceptance cycle.
  always_comb begin
    dvd_ext_s              = {MAX_W{sgn & dividend[WIDTH-1]}};
    dvd_ext_s[WIDTH-1:0]   = dividend;
    dvs_ext_s              = {MAX_W{sgn & divisor[WIDTH-1]}};
    dvs_ext_s[WIDTH-1:0]   = divisor;
    dvd_mag_s              = WIDTH'(abs_mag(dvd_ext_s, sgn));
    dvs_mag_s              = WIDTH'(abs_mag(dvs_ext_s, sgn));
    accept_s               = (state_r == S_IDLE) && start;
    div_zero_s             = (divisor == {WIDTH{1'b0}});
    load_s                 = accept_s && !div_zero_s;
    dz_ev_s                = accept_s && div_zero_s;
    min_s                  = (dividend == {1'b1, {(WIDTH-1){1'b0}}});
  end

  // Single restoring iteration shared by every CALC cycle.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .q_msb    (q_r[WIDTH-1]),
    .dvs      (dvs_r),
    .rem_next (rem_nxt_s),
    .q_bit    (q_bit_s)
  );

  // Sign correction applied when the result is published.
  always_comb begin
    if (neg_q_r) begin
      fix_q_s = {WIDTH{1'b0}} - q_r;
    end else begin
      fix_q_s = q_r;
    end
    if (neg_r_r) begin
      fix_r_s = {WIDTH{1'b0}} - rem_r[WIDTH-1:0];
    end else begin
      fix_r_s = rem_r[WIDTH-1:0];
    end
  end

  // Next-state logic: IDLE -> CALC for WIDTH iterations -> FIX -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (load_s) begin
          state_nxt_s = S_CALC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = S_FIX;
        end else begin
          state_nxt_s = S_CALC;
        end
      end
      S_FIX:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and result registers; done is a single-cycle strobe.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_r         <= {WIDTH{1'b0}};
      rem_r       <= {(WIDTH+1){1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      ovf_pend_r  <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dz_r        <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (load_s) begin
        q_r        <= dvd_mag_s;
        rem_r      <= {(WIDTH+1){1'b0}};
        dvs_r      <= dvs_mag_s;
        cnt_r      <= CNT_W'(WIDTH);
        neg_q_r    <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r_r    <= sgn & dividend[WIDTH-1];
        ovf_pend_r <= sgn & min_s & (divisor == {WIDTH{1'b1}});
        busy_r     <= 1'b1;
        dz_r       <= 1'b0;
        ovf_r      <= 1'b0;
      end else if (dz_ev_s) begin
        // Divide by zero answers immediately without entering CALC.
        quotient_r  <= {WIDTH{1'b1}};
        remainder_r <= dividend;
        dz_r        <= 1'b1;
        ovf_r       <= 1'b0;
        done_r      <= 1'b1;
      end else if (state_r == S_CALC) begin
        rem_r <= rem_nxt_s;
        q_r   <= {q_r[WIDTH-2:0], q_bit_s};
        cnt_r <= cnt_r - CNT_W'(1);
      end else if (state_r == S_FIX) begin
        quotient_r  <= fix_q_s;
        remainder_r <= fix_r_s;
        ovf_r       <= ovf_pend_r;
        dz_r        <= 1'b0;
        done_r      <= 1'b1;
        busy_r      <= 1'b0;
      end
    end
  end

  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign dz        = dz_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH = 16): the driver pushes expected
// results with their due cycle; a monitor pops and compares on every done.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk;
  logic         clr_n;
  logic         start;
  logic         sgn;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         dz;
  logic         ovf;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_vec;
  int   n_bad;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .sgn       (sgn),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dz        (dz),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter, stepped on every rising edge.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest expectation, including timing.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: done at cycle %0d with nothing pending", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient",  quotient,  e.q);
        chk("remainder", remainder, e.r);
        chk("dz",        dz,        e.dz);
        chk("ovf",       ovf,       e.ovf);
        chk("done_cycle", cyc,      e.cyc);
        chk("busy_at_done", busy,   1'b0);
      end
    end
  end

  // Issue one request from a falling edge; start is held for one cycle.
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input logic eovf);
    exp_t e;
    start    = 1'b1;
    sgn      = s;
    dividend = a;
    divisor  = b;
    e.q   = eq;
    e.r   = er;
    e.dz  = edz;
    e.ovf = eovf;
    e.cyc = cyc + 1 + (edz ? 0 : W + 1);
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'hxxxx;
    divisor  = 16'hxxxx;
  endtask

  // Bounded wait for done, sampled on falling edges.
  task automatic wait_done();
    if (done === 1'b1) return;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    n_vec++;
    n_bad++;
    $display("FAIL wait_done: no done within 40 cycles at cycle %0d", cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    clr_n    = 1'b0;
    start    = 1'b0;
    sgn      = 1'b0;
    dividend = 16'h0000;
    divisor  = 16'h0000;
    #12;
    chk("rst_quotient",  quotient,  16'h0000);
    chk("rst_remainder", remainder, 16'h0000);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_done",      done,      1'b0);
    chk("rst_flags",     {dz, ovf}, 2'b00);
    @(negedge clk);
    clr_n = 1'b1;
    idle(2);

    // Unsigned 100 / 7
    issue(1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);
    chk("busy_in_flight", busy, 1'b1);
    wait_done(); idle(2);
    // Signed -7 / 2 and 7 / -2
    issue(1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    wait_done(); idle(1);
    issue(1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0);
    wait_done(); idle(1);
    // Signed -100 / -7: positive quotient, negative remainder
    issue(1'b1, 16'hFF9C, 16'hFFF9, 16'd14, 16'hFFFE, 1'b0, 1'b0);
    wait_done(); idle(1);
    // MIN / -1 signed overflows; same operands unsigned do not
    issue(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1);
    wait_done(); idle(1);
    issue(1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0);
    wait_done(); idle(1);
    // Divide by zero, unsigned and signed; busy must stay low
    issue(1'b0, 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1'b0);
    chk("dz_busy_low0", busy, 1'b0);
    wait_done(); idle(1);
    chk("dz_busy_low1", busy, 1'b0);
    chk("dz_flag_held", dz, 1'b1);
    issue(1'b1, 16'hFFF9, 16'd0, 16'hFFFF, 16'hFFF9, 1'b1, 1'b0);
    wait_done(); idle(1);
    // Back-to-back: second start issued in the done cycle of the first
    issue(1'b0, 16'd65535, 16'd1, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    wait_done();
    issue(1'b0, 16'd40000, 16'd3, 16'd13333, 16'd1, 1'b0, 1'b0);
    chk("b2b_flags_cleared", {dz, ovf}, 2'b00);
    idle(5);
    // Start pulse while busy must be ignored
    start = 1'b1; sgn = 1'b0; dividend = 16'd5; divisor = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(); idle(2);

    // Abort with reset at E8 of an operation
    start = 1'b1; sgn = 1'b0; dividend = 16'd500; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) @(posedge clk);
    #1 clr_n = 1'b0;
    #1;
    chk("abort_quotient",  quotient,  16'h0000);
    chk("abort_remainder", remainder, 16'h0000);
    chk("abort_ctl",       {busy, done, dz, ovf}, 4'b0000);
    idle(3);
    clr_n = 1'b1;
    idle(25);
    chk("abort_no_done", done, 1'b0);
    issue(1'b0, 16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 1'b0);
    wait_done(); idle(2);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
